// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types for the AXI4-Lite register file (macro AXIL_REGFILE_SLVERR_EN)
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam resp_t OOR_RESP = RESP_SLVERR;
`else
    // Out-of-range accesses are still dropped / read as zero, just not flagged.
    localparam resp_t OOR_RESP = RESP_OKAY;
`endif

endpackage

// File: rtl/axil_regfile_decode.sv
// rtl/axil_regfile_decode.sv - combinational byte-address to register-index decode
module axil_regfile_decode
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int                    IDX_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_WIDTH-1:0]  index,
    output logic                  in_range
);

    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * 4);

    logic [ADDR_WIDTH-1:0] offset;

    assign offset   = addr - BASE_ADDR;
    // Comparing the offset avoids overflow of BASE_ADDR + SPAN at the top of the map.
    assign in_range = (addr >= BASE_ADDR) && (offset < SPAN);
    assign index    = offset[IDX_WIDTH+1:2];

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// rtl/axi_lite_regfile_slave.sv - AXI4-Lite register bank target with flat sideband view
// Out-of-range response code selected by macro AXIL_REGFILE_SLVERR_EN.
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int IDXW  = $clog2(NUM_REGS);
    localparam int STRBW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // ---------------- write channel ----------------
    wr_state_t             wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    resp_t                 bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRBW-1:0]      wstrb_q, wstrb_d;

    logic                  aw_hs, w_hs;
    logic [ADDR_WIDTH-1:0] aw_eff;
    logic [DATA_WIDTH-1:0] wdata_eff;
    logic [STRBW-1:0]      wstrb_eff;
    logic [IDXW-1:0]       wr_idx;
    logic                  wr_in_range;

    assign aw_hs     = awvalid & awready_q;
    assign w_hs      = wvalid & wready_q;
    // A payload arriving this cycle is used directly so a same-cycle AW+W commits at once.
    assign aw_eff    = aw_hs ? awaddr : awaddr_q;
    assign wdata_eff = w_hs ? wdata : wdata_q;
    assign wstrb_eff = w_hs ? wstrb : wstrb_q;

    axil_regfile_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_WIDTH  (IDXW)
    ) u_wr_decode (
        .addr     (aw_eff),
        .index    (wr_idx),
        .in_range (wr_in_range)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs) begin
                    awaddr_d  = awaddr;
                    aw_held_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                    w_held_d = 1'b1;
                end
                if (aw_held_d && w_held_d) begin
                    wr_state_d = WR_RESP;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    if (wr_in_range) begin
                        bresp_d = RESP_OKAY;
                        for (int b = 0; b < STRBW; b++) begin
                            if (wstrb_eff[b]) begin
                                regs_d[wr_idx][b*8 +: 8] = wdata_eff[b*8 +: 8];
                            end
                        end
                    end else begin
                        bresp_d = OOR_RESP;
                    end
                end else begin
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    wr_state_d = WR_IDLE;
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // ---------------- read channel ----------------
    rd_state_t             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    resp_t                 rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IDXW-1:0]       rd_idx;
    logic                  rd_in_range;

    axil_regfile_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_WIDTH  (IDXW)
    ) u_rd_decode (
        .addr     (araddr),
        .index    (rd_idx),
        .in_range (rd_in_range)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            RD_IDLE: begin
                // Reads sample regs_q, so a same-edge write is not yet visible.
                if (arvalid && arready_q) begin
                    rd_state_d = RD_DATA;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_in_range ? regs_q[rd_idx] : '0;
                    rresp_d    = rd_in_range ? RESP_OKAY : OOR_RESP;
                end else begin
                    arready_d = 1'b1;
                end
            end
            RD_DATA: begin
                if (rready) begin
                    rd_state_d = RD_IDLE;
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule
